rf_wb_ctrl: RTL and testbench

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

---
 rtl/rf_wb_ctrl_pkg.sv | 27 ++
 rtl/rf_scoreboard.sv | 45 ++++
 rtl/rf_wb_ctrl.sv | 109 ++++++++++
 tb/tb_rf_wb_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared CPU definitions used by the writeback controller and the register file.
// Contents: register-address / data widths, load byte-enable encodings, and the
// load-data formatting helper.
package rf_wb_ctrl_pkg;

  localparam int unsigned RegAdrW = 5;
  localparam int unsigned DataW   = 32;
  localparam int unsigned NumRegs = 1 << RegAdrW;

  // be[1] == 0 selects a full word regardless of be[0].
  localparam logic [1:0] BE_WORD = 2'b00;
  localparam logic [1:0] BE_BYTE = 2'b10;
  localparam logic [1:0] BE_HALF = 2'b11;

  // Zero-extends the low byte or halfword of a load; words pass through.
  function automatic logic [DataW-1:0] fmt_load(logic [DataW-1:0] data, logic [1:0] be);
    logic [DataW-1:0] res;
    res = data;
    if (be == BE_BYTE) begin
      res = {24'b0, data[7:0]};
    end else if (be == BE_HALF) begin
      res = {16'b0, data[15:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   iss_val, iss_rd     issue request marking iss_rd pending (ignored while stalled)
//   chk_srca, chk_srcb  source registers of the instruction in decode
//   clr_en, clr_adr     commit of a register-file write, clears busy[clr_adr]
//   stall               hazard on either source or on the destination
module rf_scoreboard
  import rf_wb_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               iss_val,
  input  logic [RegAdrW-1:0] iss_rd,
  input  logic [RegAdrW-1:0] chk_srca,
  input  logic [RegAdrW-1:0] chk_srcb,
  input  logic               clr_en,
  input  logic [RegAdrW-1:0] clr_adr,
  output logic               stall
);

  logic [NumRegs-1:0] busy_q, busy_d;
  logic               set_en;

  // Destination check blocks a WAW reissue until the older write commits.
  assign stall  = busy_q[chk_srca] | busy_q[chk_srcb] | busy_q[iss_rd];
  assign set_en = iss_val & ~stall & (iss_rd != '0);

  // Set is applied after clear so a same-cycle issue of the committing register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_adr] = 1'b0;
    if (set_en) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU and LSU writeback requests
// onto the single register-file write port and tracks pending destinations.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   alu_wb_val/rdy/adr/data          ALU writeback handshake
//   lsu_wb_val/rdy/adr/data/be       load writeback handshake (be selects width)
//   iss_val, iss_rd                  issue marking rd pending
//   chk_srca, chk_srcb, stall        decode hazard check
//   rf_we, rf_adr, rf_data           registered register-file write port
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_wb_val,
  output logic               alu_wb_rdy,
  input  logic [RegAdrW-1:0] alu_wb_adr,
  input  logic [DataW-1:0]   alu_wb_data,
  input  logic               lsu_wb_val,
  output logic               lsu_wb_rdy,
  input  logic [RegAdrW-1:0] lsu_wb_adr,
  input  logic [DataW-1:0]   lsu_wb_data,
  input  logic [1:0]         lsu_wb_be,
  input  logic               iss_val,
  input  logic [RegAdrW-1:0] iss_rd,
  input  logic [RegAdrW-1:0] chk_srca,
  input  logic [RegAdrW-1:0] chk_srcb,
  output logic               stall,
  output logic               rf_we,
  output logic [RegAdrW-1:0] rf_adr,
  output logic [DataW-1:0]   rf_data
);

  localparam int unsigned CntW =
      ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0]    starve_cnt_q, starve_cnt_d;
  logic               alu_force, alu_grant, lsu_grant, wb_fire;
  logic [RegAdrW-1:0] wb_adr;
  logic [DataW-1:0]   wb_data;
  logic               rf_we_q;
  logic [RegAdrW-1:0] rf_adr_q;
  logic [DataW-1:0]   rf_data_q;

  // LSU has priority; after STARVE_MAX back-to-back LSU wins the waiting ALU gets one slot.
  assign alu_force  = alu_wb_val & (starve_cnt_q == CntMax);
  assign alu_grant  = alu_wb_val & (~lsu_wb_val | alu_force);
  assign lsu_grant  = lsu_wb_val & ~alu_grant;
  assign alu_wb_rdy = alu_grant;
  assign lsu_wb_rdy = lsu_grant;
  assign wb_fire    = alu_grant | lsu_grant;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_wb_val || alu_grant) begin
      starve_cnt_d = '0;
    end else if (lsu_grant && starve_cnt_q != CntMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    if (alu_grant) begin
      wb_adr  = alu_wb_adr;
      wb_data = alu_wb_data;
    end else begin
      wb_adr  = lsu_wb_adr;
      wb_data = fmt_load(lsu_wb_data, lsu_wb_be);
    end
  end

  // Writes to x0 complete the handshake but never reach the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_adr_q     <= '0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= wb_fire & (wb_adr != '0);
      if (wb_fire) begin
        rf_adr_q  <= wb_adr;
        rf_data_q <= wb_data;
      end
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_adr  = rf_adr_q;
  assign rf_data = rf_data_q;

  // Busy bits clear on commit, not on handshake, so decode stalls through the write cycle.
  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_val  (iss_val),
    .iss_rd   (iss_rd),
    .chk_srca (chk_srca),
    .chk_srcb (chk_srcb),
    .clr_en   (rf_we_q),
    .clr_adr  (rf_adr_q),
    .stall    (stall)
  );

endmodule

// File: tb/tb_rf_wb_ctrl.sv
module tb_rf_wb_ctrl;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wb_val, alu_wb_rdy;
  logic [4:0]  alu_wb_adr;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_val, lsu_wb_rdy;
  logic [4:0]  lsu_wb_adr;
  logic [31:0] lsu_wb_data;
  logic [1:0]  lsu_wb_be;
  logic        iss_val;
  logic [4:0]  iss_rd, chk_srca, chk_srcb;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_adr;
  logic [31:0] rf_data;

  always #5 clk = ~clk;

  rf_wb_ctrl #(
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_wb_val  (alu_wb_val),
    .alu_wb_rdy  (alu_wb_rdy),
    .alu_wb_adr  (alu_wb_adr),
    .alu_wb_data (alu_wb_data),
    .lsu_wb_val  (lsu_wb_val),
    .lsu_wb_rdy  (lsu_wb_rdy),
    .lsu_wb_adr  (lsu_wb_adr),
    .lsu_wb_data (lsu_wb_data),
    .lsu_wb_be   (lsu_wb_be),
    .iss_val     (iss_val),
    .iss_rd      (iss_rd),
    .chk_srca    (chk_srca),
    .chk_srcb    (chk_srcb),
    .stall       (stall),
    .rf_we       (rf_we),
    .rf_adr      (rf_adr),
    .rf_data     (rf_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending-register set, LSU win streak, and the write due next cycle.
  bit          m_busy [32];
  int          m_streak;
  bit          m_we;
  logic [4:0]  m_adr;
  logic [31:0] m_data;
  bit          last_alu_g, last_lsu_g;

  function automatic logic [31:0] ref_load(logic [31:0] d, logic [1:0] be);
    if (be == 2'b10) return d & 32'h0000_00FF;
    if (be == 2'b11) return d & 32'h0000_FFFF;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_streak = 0;
    m_we     = 0;
    m_adr    = '0;
    m_data   = '0;
  endtask

  task automatic idle_inputs();
    alu_wb_val = 0; alu_wb_adr = '0; alu_wb_data = '0;
    lsu_wb_val = 0; lsu_wb_adr = '0; lsu_wb_data = '0; lsu_wb_be = '0;
    iss_val = 0; iss_rd = '0; chk_srca = '0; chk_srcb = '0;
  endtask

  // One clock cycle: inputs are already driven; checks combinational outputs mid-cycle
  // and registered outputs just after the edge.
  task automatic step();
    bit alu_g, lsu_g, exp_stall;
    #1;
    exp_stall = m_busy[chk_srca] || m_busy[chk_srcb] || m_busy[iss_rd];
    alu_g = alu_wb_val && (!lsu_wb_val || m_streak >= STARVE_MAX);
    lsu_g = lsu_wb_val && !alu_g;
    check("alu_wb_rdy", 32'(alu_wb_rdy), 32'(alu_g));
    check("lsu_wb_rdy", 32'(lsu_wb_rdy), 32'(lsu_g));
    check("stall", 32'(stall), 32'(exp_stall));
    last_alu_g = alu_g;
    last_lsu_g = lsu_g;
    @(posedge clk);
    if (m_we) m_busy[m_adr] = 0;
    if (iss_val && !exp_stall && iss_rd != 0) m_busy[iss_rd] = 1;
    if (alu_g || !alu_wb_val) m_streak = 0;
    else if (lsu_g && m_streak < STARVE_MAX) m_streak++;
    m_we = 0;
    if (alu_g) begin
      m_we = (alu_wb_adr != 0); m_adr = alu_wb_adr; m_data = alu_wb_data;
    end else if (lsu_g) begin
      m_we = (lsu_wb_adr != 0); m_adr = lsu_wb_adr;
      m_data = ref_load(lsu_wb_data, lsu_wb_be);
    end
    #1;
    check("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      check("rf_adr", 32'(rf_adr), 32'(m_adr));
      check("rf_data", rf_data, m_data);
    end
  endtask

  bit lsu_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic [1:0] be_tab [3] = '{2'b10, 2'b11, 2'b00};
  logic [31:0] fmt_tab [3] = '{32'h0000_00EF, 32'h0000_BEEF, 32'hDEAD_BEEF};

  initial begin
    idle_inputs();
    model_reset();
    last_alu_g = 0;
    last_lsu_g = 0;
    reset = 0;
    alu_wb_val = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_adr", 32'(rf_adr), 32'd0);
    check("reset_rf_data", rf_data, 32'd0);
    check("reset_alu_rdy", 32'(alu_wb_rdy), 32'd1);
    alu_wb_val = 0;
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    reset = 1;
    step();

    // ALU-only write
    alu_wb_val = 1; alu_wb_adr = 5; alu_wb_data = 32'h1234;
    step();
    check("alu_only_rdy", 32'(last_alu_g), 32'd1);
    alu_wb_val = 0;
    #1;
    check("alu_only_we", 32'(rf_we), 32'd1);
    check("alu_only_adr", 32'(rf_adr), 32'd5);
    check("alu_only_data", rf_data, 32'h1234);
    step();

    // Starvation guard with both requesters continuously valid
    alu_wb_val = 1; alu_wb_adr = 1; alu_wb_data = 32'hA;
    lsu_wb_val = 1; lsu_wb_adr = 2; lsu_wb_data = 32'hB; lsu_wb_be = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      check("starve_seq", 32'(last_lsu_g), 32'(lsu_seq[i]));
    end
    idle_inputs();
    step();

    // Load formatting
    for (int i = 0; i < 3; i++) begin
      lsu_wb_val = 1; lsu_wb_adr = 3; lsu_wb_data = 32'hDEAD_BEEF; lsu_wb_be = be_tab[i];
      step();
      check("lsu_fmt", rf_data, fmt_tab[i]);
      lsu_wb_val = 0;
    end
    step();

    // Scoreboard: stall on rd=7 until its commit retires
    iss_val = 1; iss_rd = 7;
    step();
    iss_val = 0; iss_rd = 0; chk_srca = 7;
    step();
    check("busy7_stall", 32'(stall), 32'd1);
    step();
    alu_wb_val = 1; alu_wb_adr = 7; alu_wb_data = 32'h77;
    step();
    alu_wb_val = 0;
    check("commit_cycle_stall", 32'(stall), 32'd1);
    step();
    check("after_commit_stall", 32'(stall), 32'd0);
    // Commit to 7 while 7 is re-issued: set wins
    alu_wb_val = 1; alu_wb_adr = 7; alu_wb_data = 32'h78;
    chk_srca = 0;
    step();
    alu_wb_val = 0; iss_val = 1; iss_rd = 7;
    step();
    iss_val = 0; iss_rd = 0; chk_srca = 7;
    step();
    check("set_wins_stall", 32'(stall), 32'd1);
    alu_wb_val = 1; alu_wb_adr = 7; alu_wb_data = 32'h79;
    step();
    idle_inputs();
    step();
    step();

    // Writes to x0 are accepted but dropped; rd=0 never stalls
    alu_wb_val = 1; alu_wb_adr = 0; alu_wb_data = 32'hFF;
    iss_val = 1; iss_rd = 0;
    step();
    check("adr0_rdy", 32'(last_alu_g), 32'd1);
    check("adr0_we", 32'(rf_we), 32'd0);
    idle_inputs();
    check("rd0_stall", 32'(stall), 32'd0);
    step();

    // Reset mid-stream with busy[9] and a handshake in flight
    iss_val = 1; iss_rd = 9;
    step();
    iss_val = 0; iss_rd = 0; chk_srca = 9;
    step();
    alu_wb_val = 1; alu_wb_adr = 9; alu_wb_data = 32'hCAFE;
    #1;
    check("rst_hs_rdy", 32'(alu_wb_rdy), 32'd1);
    reset = 0;
    model_reset();
    #1;
    check("rst_async_we", 32'(rf_we), 32'd0);
    check("rst_async_adr", 32'(rf_adr), 32'd0);
    check("rst_async_data", rf_data, 32'd0);
    check("rst_busy_clear", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_we", 32'(rf_we), 32'd0);
    alu_wb_val = 0;
    #3;
    reset = 1;
    step();
    check("rst_release_we", 32'(rf_we), 32'd0);
    step();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      alu_wb_val  = 1'($urandom_range(0, 1));
      alu_wb_adr  = 5'($urandom_range(0, 7));
      alu_wb_data = $urandom;
      lsu_wb_val  = ($urandom_range(0, 3) != 0);
      lsu_wb_adr  = 5'($urandom_range(0, 7));
      lsu_wb_data = $urandom;
      lsu_wb_be   = 2'($urandom_range(0, 3));
      iss_val     = 1'($urandom_range(0, 1));
      iss_rd      = 5'($urandom_range(0, 7));
      chk_srca    = 5'($urandom_range(0, 7));
      chk_srcb    = 5'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
